// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state encodings for the UART peripheral.
//   - TX/RX FSM state enums (parity states present only with UART_PERIPHERAL_PARITY_EN)
//   - status register bit indices
//   - idle line level
package uart_pkg;

  localparam logic IDLE_LEVEL = 1'b1;

  localparam int unsigned STAT_TX_DONE   = 0;
  localparam int unsigned STAT_TX_ACTIVE = 1;
  localparam int unsigned STAT_RX_VALID  = 2;

`ifdef UART_PERIPHERAL_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_STOP   = 3'd3,
    TX_PARITY = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_STOP   = 3'd3,
    RX_PARITY = 3'd4
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3
  } rx_state_e;
`endif

endpackage

// File: rtl/uart_rx.sv
// uart_rx: UART receiver -- 2-flop synchronizer, start-bit detect with glitch reject,
// mid-bit sampling of 8 data bits (LSB first), stop-bit check.
// Optional feature macro: UART_PERIPHERAL_PARITY_EN (even parity bit after bit 7;
// a parity mismatch drops the byte like a framing error).
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   rx_serial_i  asynchronous serial line in
//   rx_byte_o    assembled byte, valid while rx_load_o is high
//   rx_load_o    one-cycle strobe: a well-framed byte completes on this edge
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned ClksPerBit = 87
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_serial_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_load_o
);

  localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);
  // Start detect already lags the line edge, so resampling after ClksPerBit/2 edges lands
  // near the middle of the start bit; every later sample is one full bit apart.
  localparam logic [CntW-1:0] HalfCnt = CntW'(ClksPerBit / 2 - 1);

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      sync_q;
  logic            prev_q;
  logic            rx_s;
`ifdef UART_PERIPHERAL_PARITY_EN
  logic            parity_ok_q, parity_ok_d;
`endif

  assign rx_s      = sync_q[1];
  assign rx_byte_o = shift_q;

  // Synchronizer and edge-detect history reset to the idle level so that reset release
  // never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {IDLE_LEVEL, IDLE_LEVEL};
      prev_q <= IDLE_LEVEL;
    end else begin
      sync_q <= {sync_q[0], rx_serial_i};
      prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
`ifdef UART_PERIPHERAL_PARITY_EN
      parity_ok_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
`ifdef UART_PERIPHERAL_PARITY_EN
      parity_ok_q <= parity_ok_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_load_o   = 1'b0;
`ifdef UART_PERIPHERAL_PARITY_EN
    parity_ok_d = parity_ok_q;
`endif
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HalfCnt) begin
          cnt_d   = '0;
          bit_d   = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PERIPHERAL_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef UART_PERIPHERAL_PARITY_EN
      RX_PARITY: begin
        if (cnt_q == LastCnt) begin
          cnt_d       = '0;
          parity_ok_d = (rx_s == ^shift_q);
          state_d     = RX_STOP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
`ifdef UART_PERIPHERAL_PARITY_EN
          rx_load_o = (rx_s == IDLE_LEVEL) && parity_ok_q;
`else
          rx_load_o = (rx_s == IDLE_LEVEL);
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_peripheral.sv
// uart_peripheral: full-duplex UART with CPU-facing send/receive handshake.
// Optional feature macro: UART_PERIPHERAL_PARITY_EN (8E1 frames instead of 8N1).
// Ports:
//   in_clk           system clock (rising edge)
//   in_reset_n       asynchronous active-low reset
//   in_send_en       request to transmit in_tx_data[7:0]; honoured only while TX is idle
//   in_tx_data       transmit word, bits [31:8] ignored
//   in_data_is_read  CPU acknowledge; clears rx_data_valid on the next edge
//   in_rx_serial     serial line in (asynchronous)
//   out_tx_serial    serial line out, idles high
//   out_rx_data      last well-framed byte received
//   out_status       {rx_data_valid, tx_active, tx_done}
module uart_peripheral
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic        in_clk,
  input  logic        in_reset_n,
  input  logic        in_send_en,
  input  logic [31:0] in_tx_data,
  input  logic        in_data_is_read,
  input  logic        in_rx_serial,
  output logic        out_tx_serial,
  output logic [7:0]  out_rx_data,
  output logic [2:0]  out_status
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_serial_q, tx_serial_d;
  logic            tx_active_q, tx_active_d;
  logic            tx_done_q, tx_done_d;
  logic            tx_bit_end;

  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_byte;
  logic            rx_load;

  logic            unused_tx_hi;
  assign unused_tx_hi = ^in_tx_data[31:8];

  uart_rx #(
    .ClksPerBit (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk_i       (in_clk),
    .rst_ni      (in_reset_n),
    .rx_serial_i (in_rx_serial),
    .rx_byte_o   (rx_byte),
    .rx_load_o   (rx_load)
  );

  // TX next state. The serial output is registered from the next state so the line
  // changes exactly on the bit-boundary edge and never glitches.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = tx_done_q;
    tx_bit_end = (tx_cnt_q == LastCnt);

    if (tx_state_q != TX_IDLE) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CntW'(1);
    end

    case (tx_state_q)
      TX_IDLE: begin
        if (in_send_en) begin
          tx_state_d = TX_START;
          tx_shift_d = in_tx_data[7:0];
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_done_d  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_end) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) begin
`ifdef UART_PERIPHERAL_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end
        end
      end
`ifdef UART_PERIPHERAL_PARITY_EN
      TX_PARITY: begin
        if (tx_bit_end) tx_state_d = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_state_d = TX_IDLE;
          tx_done_d  = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    case (tx_state_d)
      TX_START:  tx_serial_d = 1'b0;
      TX_DATA:   tx_serial_d = tx_shift_d[tx_bit_d];
`ifdef UART_PERIPHERAL_PARITY_EN
      TX_PARITY: tx_serial_d = ^tx_shift_d;
`endif
      default:   tx_serial_d = IDLE_LEVEL;
    endcase

    tx_active_d = (tx_state_d != TX_IDLE);
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_serial_q <= IDLE_LEVEL;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

  // A completing byte beats a simultaneous read acknowledge; overrun overwrites.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (rx_load) begin
      rx_data_d  = rx_byte;
      rx_valid_d = 1'b1;
    end else if (in_data_is_read) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    out_status                 = '0;
    out_status[STAT_TX_DONE]   = tx_done_q;
    out_status[STAT_TX_ACTIVE] = tx_active_q;
    out_status[STAT_RX_VALID]  = rx_valid_q;
  end

  assign out_tx_serial = tx_serial_q;
  assign out_rx_data   = rx_data_q;

endmodule

// File: tb/tb_uart_peripheral.sv
// tb_uart_peripheral: randomized scoreboard bench for uart_peripheral (CLKS_PER_BIT=4).
// Transmitted bytes are decoded from the line by a monitor; received bytes are detected
// by a monitor on the status/data outputs. Both pop expectations from queues.
module tb_uart_peripheral;

  localparam int unsigned CPB = 4;
`ifdef UART_PERIPHERAL_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  logic        in_clk = 1'b0;
  logic        in_reset_n = 1'b1;
  logic        in_send_en = 1'b0;
  logic [31:0] in_tx_data = '0;
  logic        in_data_is_read = 1'b0;
  logic        in_rx_serial = 1'b1;
  logic        out_tx_serial;
  logic [7:0]  out_rx_data;
  logic [2:0]  out_status;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  rx_last;

  uart_peripheral #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .in_clk          (in_clk),
    .in_reset_n      (in_reset_n),
    .in_send_en      (in_send_en),
    .in_tx_data      (in_tx_data),
    .in_data_is_read (in_data_is_read),
    .in_rx_serial    (in_rx_serial),
    .out_tx_serial   (out_tx_serial),
    .out_rx_data     (out_rx_data),
    .out_status      (out_status)
  );

  always #5 in_clk = ~in_clk;

  // Line order: element 0 goes out first.
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] d, input logic stop);
    logic [NB-1:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = d[i];
`ifdef UART_PERIPHERAL_PARITY_EN
    f[9] = ^d;
`endif
    f[NB-1] = stop;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_tx_data = {24'($urandom), d};
    in_send_en = 1'b1;
    tick(1);
    in_send_en = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (out_status[1] && n < 20 * NB * CPB) begin
      tick(1);
      n++;
    end
    check("tx_idle_timeout", {31'd0, out_status[1]}, 32'd0);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    logic [NB-1:0] f;
    f = frame_bits(d, stop);
    for (int i = 0; i < NB; i++) begin
      in_rx_serial = f[i];
      tick(CPB);
    end
    in_rx_serial = 1'b1;
  endtask

  // TX monitor: decode frames from the line, sampling 1.5 cycles into the start bit and
  // then once per bit period. A reset seen mid-frame abandons the frame.
  initial begin : tx_mon
    logic [NB-1:0] got;
    logic          abort;
    logic [7:0]    e;
    forever begin
      @(negedge in_clk);
      if (in_reset_n && out_tx_serial == 1'b0) begin
        abort = 1'b0;
        @(negedge in_clk);
        for (int i = 0; i < NB; i++) begin
          got[i] = out_tx_serial;
          if (!in_reset_n) abort = 1'b1;
          if (i < NB - 1) begin
            for (int k = 0; k < CPB; k++) begin
              @(negedge in_clk);
              if (!in_reset_n) abort = 1'b1;
            end
          end
        end
        if (!abort) begin
          check("tx_start_bit", {31'd0, got[0]}, 32'd0);
          check("tx_stop_bit", {31'd0, got[NB-1]}, 32'd1);
`ifdef UART_PERIPHERAL_PARITY_EN
          check("tx_parity", {31'd0, got[9]}, {31'd0, ^got[8:1]});
`endif
          check("tx_pending", (tx_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
          if (tx_q.size() > 0) begin
            e = tx_q.pop_front();
            check("tx_byte", {24'd0, got[8:1]}, {24'd0, e});
          end
        end
      end
    end
  end

  // RX monitor: a new byte is presented when valid rises, or valid stays high and the
  // data changes (overrun).
  initial begin : rx_mon
    logic       pv;
    logic [7:0] pd;
    logic [7:0] e;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge in_clk);
      if (!in_reset_n) begin
        pv = 1'b0;
        pd = '0;
      end else begin
        if (out_status[2] && (!pv || out_rx_data != pd)) begin
          check("rx_pending", (rx_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
          if (rx_q.size() > 0) begin
            e = rx_q.pop_front();
            check("rx_byte", {24'd0, out_rx_data}, {24'd0, e});
          end
        end
        pv = out_status[2];
        pd = out_rx_data;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [NB-1:0] f;
    logic [7:0]    d;
    int            n;

    // Asynchronous reset, checked before any clock edge.
    #1 in_reset_n = 1'b0;
    #2;
    check("rst_tx_line", {31'd0, out_tx_serial}, 32'd1);
    check("rst_rx_data", {24'd0, out_rx_data}, 32'd0);
    check("rst_status", {29'd0, out_status}, 32'd0);
    tick(3);
    in_reset_n = 1'b1;
    tick(4);
    check("post_rst_status", {29'd0, out_status}, 32'd0);

    // 0xA5 frame, cycle-exact waveform; acceptance edge is cycle 0.
    f = frame_bits(8'hA5, 1'b1);
    tx_q.push_back(8'hA5);
    in_tx_data = 32'h0000_00A5;
    in_send_en = 1'b1;
    tick(1);
    in_send_en = 1'b0;
    for (int k = 0; k < NB * CPB; k++) begin
      check("a5_line", {31'd0, out_tx_serial}, {31'd0, f[k / CPB]});
      check("a5_status_busy", {29'd0, out_status}, 32'd2);
      tick(1);
    end
    check("a5_done_status", {29'd0, out_status}, 32'd1);
    check("a5_idle_line", {31'd0, out_tx_serial}, 32'd1);
    tick(5);
    check("a5_done_sticky", {29'd0, out_status}, 32'd1);

    // Send while busy is ignored.
    tx_q.push_back(8'hFF);
    send(8'hFF);
    tick(9);
    send(8'h00);
    wait_tx_idle();
    check("busy_send_status", {29'd0, out_status}, 32'd1);
    tick(3);
    check("busy_send_no_frame", {31'd0, out_status[1]}, 32'd0);

    // Back-to-back: send held through the end of a frame starts the next immediately.
    tx_q.push_back(8'h81);
    tx_q.push_back(8'h42);
    in_tx_data = 32'h81;
    in_send_en = 1'b1;
    tick(1);
    in_tx_data = 32'h42;
    n = 0;
    while (out_status[1] && n < 4 * NB * CPB) begin
      tick(1);
      n++;
    end
    check("b2b_first_done", {29'd0, out_status}, 32'd1);
    tick(1);
    in_send_en = 1'b0;
    check("b2b_second_start", {29'd0, out_status}, 32'd2);
    check("b2b_start_line", {31'd0, out_tx_serial}, 32'd0);
    wait_tx_idle();

    // RX 0x3C. The stop bit is sampled 3 (sync + edge detect) + CPB/2 cycles after the
    // last bit period begins, i.e. one edge after rx_frame returns when CPB=4.
    rx_q.push_back(8'h3C);
    rx_frame(8'h3C, 1'b1);
    tick(1);
    check("rx3c_data", {24'd0, out_rx_data}, 32'h3C);
    check("rx3c_valid", {31'd0, out_status[2]}, 32'd1);
    in_data_is_read = 1'b1;
    tick(1);
    in_data_is_read = 1'b0;
    check("rx3c_read_clears", {31'd0, out_status[2]}, 32'd0);
    check("rx3c_data_kept", {24'd0, out_rx_data}, 32'h3C);

    // Framing error: byte dropped.
    rx_frame(8'h11, 1'b0);
    tick(4);
    check("rx_ferr_data", {24'd0, out_rx_data}, 32'h3C);
    check("rx_ferr_valid", {31'd0, out_status[2]}, 32'd0);

    // One-cycle low glitch is rejected.
    in_rx_serial = 1'b0;
    tick(1);
    in_rx_serial = 1'b1;
    tick(NB * CPB);
    check("rx_glitch_valid", {31'd0, out_status[2]}, 32'd0);
    check("rx_glitch_data", {24'd0, out_rx_data}, 32'h3C);

    // Read acknowledge on the load edge: load wins.
    rx_q.push_back(8'h77);
    rx_frame(8'h77, 1'b1);
    in_data_is_read = 1'b1;
    tick(1);
    in_data_is_read = 1'b0;
    check("rx77_data", {24'd0, out_rx_data}, 32'h77);
    check("rx77_valid", {31'd0, out_status[2]}, 32'd1);
    tick(1);
    check("rx77_valid_held", {31'd0, out_status[2]}, 32'd1);

    // Overrun: second byte overwrites, valid stays high.
    rx_q.push_back(8'h5A);
    rx_frame(8'h5A, 1'b1);
    tick(2);
    rx_q.push_back(8'hC3);
    rx_frame(8'hC3, 1'b1);
    tick(2);
    check("ovr_data", {24'd0, out_rx_data}, 32'hC3);
    check("ovr_valid", {31'd0, out_status[2]}, 32'd1);
    in_data_is_read = 1'b1;
    tick(1);
    in_data_is_read = 1'b0;
    rx_last = 8'hC3;

    // Random full-duplex traffic.
    fork
      begin : tx_rand
        logic [7:0] td;
        for (int i = 0; i < 12; i++) begin
          td = 8'($urandom);
          tx_q.push_back(td);
          send(td);
          if ($urandom_range(0, 2) == 0) begin
            tick($urandom_range(1, 30));
            send(8'($urandom));
          end
          wait_tx_idle();
          tick($urandom_range(0, 3));
        end
      end
      begin : rx_rand
        logic [7:0] rd;
        logic       good;
        for (int i = 0; i < 12; i++) begin
          rd   = 8'($urandom);
          good = ($urandom_range(0, 4) != 0);
          if (good) rx_q.push_back(rd);
          rx_frame(rd, good);
          tick(3 + $urandom_range(0, 4));
          if (good) begin
            rx_last = rd;
            in_data_is_read = 1'b1;
            tick(1);
            in_data_is_read = 1'b0;
            check("rand_rx_read_clears", {31'd0, out_status[2]}, 32'd0);
          end else begin
            check("rand_rx_ferr_valid", {31'd0, out_status[2]}, 32'd0);
            check("rand_rx_ferr_data", {24'd0, out_rx_data}, {24'd0, rx_last});
          end
        end
      end
    join

    // Reset at cycle 15 of a TX frame: line and status drop without a clock edge.
    d = 8'h5A;
    f = frame_bits(d, 1'b1);
    send(d);
    tick(15);
    check("rst_mid_line_before", {31'd0, out_tx_serial}, {31'd0, f[15 / CPB]});
    in_reset_n = 1'b0;
    #1;
    check("rst_mid_line", {31'd0, out_tx_serial}, 32'd1);
    check("rst_mid_status", {29'd0, out_status}, 32'd0);
    check("rst_mid_rx_data", {24'd0, out_rx_data}, 32'd0);
    tick(6);
    in_reset_n = 1'b1;
    tick(NB * CPB);
    check("post_abort_status", {29'd0, out_status}, 32'd0);
    check("post_abort_line", {31'd0, out_tx_serial}, 32'd1);
    check("post_abort_rx_data", {24'd0, out_rx_data}, 32'd0);

    tick(4);
    check("tx_queue_drained", tx_q.size(), 32'd0);
    check("rx_queue_drained", rx_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
